// File: rtl/alu_mult_sequencer.sv
// rtl/alu_mult_sequencer.sv - shift-add multiply sequencer that borrows the shared ALU adder.
// Optional MULT_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are all zero.
package alu_mult_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module alu_mult_sequencer
  import alu_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  input  logic [WIDTH-1:0] ex_rdat1,
  input  logic [WIDTH-1:0] ex_rdat2,
  input  logic [WIDTH-1:0] ex_instr,
  input  aluop_t           ex_aluop,
  input  logic             ex_alusrc,
  output logic [WIDTH-1:0] alu_rdat1,
  output logic [WIDTH-1:0] alu_rdat2,
  output logic [WIDTH-1:0] alu_instr,
  output aluop_t           alu_aluop,
  output logic             alu_alusrc,
  input  logic [WIDTH-1:0] alu_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] mp_q, mp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0] acc_nxt;
  logic             early_exit;

`ifdef MULT_EARLY_EXIT_EN
  assign early_exit = (mp_q == '0);
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mc_q      <= '0;
      mp_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mc_q      <= mc_d;
      mp_q      <= mp_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mc_d       = mc_q;
    mp_d       = mp_q;
    cnt_d      = cnt_q;
    product_d  = product_q;
    acc_nxt    = acc_q;
    busy       = 1'b0;
    done       = 1'b0;
    alu_rdat1  = ex_rdat1;
    alu_rdat2  = ex_rdat2;
    alu_instr  = ex_instr;
    alu_aluop  = ex_aluop;
    alu_alusrc = ex_alusrc;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          mc_d    = mcand;
          mp_d    = mplier;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy       = 1'b1;
        alu_rdat1  = acc_q;
        alu_rdat2  = mc_q;
        alu_aluop  = ALU_ADD;
        alu_alusrc = 1'b0;
        alu_instr  = '0;
        if (early_exit) begin
          state_d   = DONE;
          product_d = acc_q;
        end else begin
          // Shifts stay local so the ALU only ever sees the partial-product add.
          acc_nxt = mp_q[0] ? alu_out : acc_q;
          acc_d   = acc_nxt;
          mc_d    = mc_q << 1;
          mp_d    = mp_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d   = DONE;
            product_d = acc_nxt;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb/tb_alu_mult_sequencer.sv - directed table-driven bench for alu_mult_sequencer.
// Expected latency follows MULT_EARLY_EXIT_EN when the bench is built with it.
module tb_alu_mult_sequencer;
  import alu_mult_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [31:0] mcand = '0, mplier = '0;
  logic        busy, done;
  logic [31:0] product;
  logic [31:0] ex_rdat1 = '0, ex_rdat2 = '0, ex_instr = '0;
  aluop_t      ex_aluop = ALU_SUB;
  logic        ex_alusrc = 1'b0;
  logic [31:0] alu_rdat1, alu_rdat2, alu_instr;
  aluop_t      alu_aluop;
  logic        alu_alusrc;
  logic [31:0] alu_out;

  int checks = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  alu_mult_sequencer #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product),
    .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2), .ex_instr(ex_instr),
    .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
    .alu_rdat1(alu_rdat1), .alu_rdat2(alu_rdat2), .alu_instr(alu_instr),
    .alu_aluop(alu_aluop), .alu_alusrc(alu_alusrc), .alu_out(alu_out)
  );

  // Behavioural stand-in for the shared ALU.
  logic [31:0] alu_b;
  always_comb begin
    alu_b = alu_alusrc ? {{16{alu_instr[15]}}, alu_instr[15:0]} : alu_rdat2;
    case (alu_aluop)
      ALU_ADD: alu_out = alu_rdat1 + alu_b;
      ALU_SUB: alu_out = alu_rdat1 - alu_b;
      ALU_AND: alu_out = alu_rdat1 & alu_b;
      ALU_OR:  alu_out = alu_rdat1 | alu_b;
      ALU_XOR: alu_out = alu_rdat1 ^ alu_b;
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic int exp_lat(input logic [31:0] m);
`ifdef MULT_EARLY_EXIT_EN
    int k;
    k = -1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i;
    if (k < 0) return 2;
    return (3 + k > 33) ? 33 : 3 + k;
`else
    return 33 + 0 * int'(m[0]);
`endif
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Launch one multiply and observe 36 cycles; optionally re-pulse start in cycle inj.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int inj,
                          input logic [31:0] prev, output int lat, output int ndone,
                          output int nbusy, output logic [31:0] prod,
                          output int bad_op, output int bad_hold);
    mcand = a; mplier = b; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0; ndone = 0; nbusy = 0; prod = 32'hxxxxxxxx; bad_op = 0; bad_hold = 0;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat  = cyc;
          prod = product;
        end
        if (alu_aluop !== ex_aluop || alu_rdat1 !== ex_rdat1) bad_op++;
      end else if (busy) begin
        if (alu_aluop !== ALU_ADD || alu_alusrc !== 1'b0 || alu_instr !== 32'h0) bad_op++;
        if (product !== prev) bad_hold++;
      end
      start = (cyc == inj);
      if (cyc == inj) begin
        mcand  = 32'h0000DEAD;
        mplier = 32'h0000BEEF;
      end
      step();
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    int          inj;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, nd, nb, bo, bh;
    logic [31:0] prod, prev;

    vecs[0] = '{32'd6,        32'd7,        32'd42,         0};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   0};
    vecs[2] = '{32'h80000000, 32'd2,        32'h00000000,   0};
    vecs[3] = '{32'd9,        32'd3,        32'd27,         0};
    vecs[4] = '{32'h00001234, 32'h00005678, 32'h06260060,   0};
    vecs[5] = '{32'h12345678, 32'd0,        32'd0,          0};
    vecs[6] = '{32'h00010001, 32'h00010001, 32'h00020001,   0};
    vecs[7] = '{32'd11,       32'd7,        32'd77,         3};
    vecs[8] = '{32'd3,        32'h80000001, 32'h80000003,  10};

    repeat (3) step();
    RST = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_product", product, 32'd0);

    ex_aluop = ALU_SUB; ex_rdat1 = 32'd7; ex_rdat2 = 32'd3; ex_instr = 32'h0000ABCD; ex_alusrc = 1'b0;
    #1;
    chk("pass_rdat1", alu_rdat1, 32'd7);
    chk("pass_rdat2", alu_rdat2, 32'd3);
    chk("pass_instr", alu_instr, 32'h0000ABCD);
    chk("pass_aluop", 32'(alu_aluop), 32'(ALU_SUB));
    chk("pass_alusrc", {31'b0, alu_alusrc}, 32'd0);
    chk("pass_alu_out", alu_out, 32'd4);
    step();

    prev = 32'd0;
    for (int i = 0; i < 9; i++) begin
      run_mult(vecs[i].a, vecs[i].b, vecs[i].inj, prev, lat, nd, nb, prod, bo, bh);
      chk($sformatf("v%0d_product", i), prod, vecs[i].p);
      chk($sformatf("v%0d_done_cycle", i), 32'(lat), 32'(exp_lat(vecs[i].b)));
      chk($sformatf("v%0d_done_count", i), 32'(nd), 32'd1);
      chk($sformatf("v%0d_busy_cycles", i), 32'(nb), 32'(exp_lat(vecs[i].b)));
      chk($sformatf("v%0d_alu_ownership", i), 32'(bo), 32'd0);
      chk($sformatf("v%0d_product_hold", i), 32'(bh), 32'd0);
      chk($sformatf("v%0d_product_after", i), product, vecs[i].p);
      prev = vecs[i].p;
    end

    // Reset in cycle 10 of a long multiply aborts it without a done pulse.
    mcand = 32'd3; mplier = 32'hFFFFFFFF; start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) step();
    chk("abort_busy_before", {31'b0, busy}, 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_product", product, 32'd0);
    nd = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done || busy) nd++;
      step();
    end
    chk("abort_no_activity", 32'(nd), 32'd0);

    run_mult(32'd5, 32'd5, 0, 32'd0, lat, nd, nb, prod, bo, bh);
    chk("after_abort_product", prod, 32'd25);
    chk("after_abort_done_cycle", 32'(lat), 32'(exp_lat(32'd5)));

    // Reset wins over a simultaneous start.
    RST = 1'b1; start = 1'b1; mcand = 32'd2; mplier = 32'd3;
    step();
    RST = 1'b0; start = 1'b0;
    chk("rst_start_busy", {31'b0, busy}, 32'd0);
    step();
    chk("rst_start_busy_next", {31'b0, busy}, 32'd0);
    chk("rst_start_product", product, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
